// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bist_pkg
//  Description : Shared definitions for the BIST session scheduler: FSM state
//                encoding, default widths and a small state-class helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bist_pkg;

  // Default configuration values
  localparam int DEF_N_REQ       = 4;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_TO_W        = 16;
  localparam int DEF_TIMEOUT_CYC = 1000;

  // Session FSM. ST_KILL is the one-cycle controller reset issued when the
  // watchdog expires; it is unreachable unless the watchdog is built in.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4,
    ST_KILL  = 3'd5
  } bist_state_e;

  // States during which the controller is started and the watchdog counts
  function automatic logic is_active(input bist_state_e s);
    return (s == ST_START) || (s == ST_RUN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. Returns a one-hot vector
//                selecting the first set request at or after the pointer,
//                wrapping around. All-zero when no request is set.
//  Ports       : req [N_REQ]  request vector
//                ptr [PTR_W]  highest-priority index
//                gnt [N_REQ]  one-hot pick
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = PTR_W'((int'(ptr) + off) % N_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bist_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bist_scheduler
//  Description : Round-robin scheduler sharing one BIST controller among
//                N_REQ cores. Each session: controller reset pulse, start,
//                wait for bist_end, capture the result, pulse done.
//  Ports       : clk, reset (async, active-low)
//                req[N_REQ]      level requests, held until done
//                gnt[N_REQ]      registered one-hot grant for the session
//                done[N_REQ]     one-cycle completion pulse
//                pass, timeout   result qualifiers, valid with done
//                session_cnt     completed sessions (wrapping)
//                bist_start, bist_reset     to controller
//                bist_running, bist_end, bist_out  from controller
//  Config      : BIST_TIMEOUT_EN - adds a START/RUN watchdog that kills a
//                session after TIMEOUT_CYC cycles (pass=0, timeout=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_scheduler
  import bist_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TO_W        = DEF_TO_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] session_cnt,
  output logic             bist_start,
  output logic             bist_reset,
  input  logic             bist_running,
  input  logic             bist_end,
  input  logic             bist_out
);

  localparam int PTR_W = $clog2(N_REQ);

  bist_state_e      state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  // owner survives the gnt drop in DONE so done/pointer know who finished
  logic [N_REQ-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] pick;
  logic [PTR_W-1:0] ptr_next;
  logic             wd_expire;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick)
  );

  // Pointer moves to the slot after the finishing owner, so a waiting
  // requester always beats a re-request from the same core.
  always_comb begin
    ptr_next = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q[i]) begin
        ptr_next = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register and datapath flops
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. bist_end takes precedence over watchdog expiry.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|req) state_d = ST_GRANT;
      ST_GRANT: state_d = ST_START;
      ST_START: begin
        if (bist_end)          state_d = ST_DONE;
        else if (wd_expire)    state_d = ST_KILL;
        else if (bist_running) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bist_end)          state_d = ST_DONE;
        else if (wd_expire)    state_d = ST_KILL;
      end
      ST_KILL:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = pick;
          owner_d = pick;
        end
      end
      ST_START, ST_RUN: begin
        if (bist_end) begin
          gnt_d  = '0;
          pass_d = bist_out;
        end
      end
      ST_KILL: begin
        gnt_d  = '0;
        pass_d = 1'b0;
      end
      ST_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        ptr_d = ptr_next;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs (Moore decode of the registered state; clear with async reset)
  // --------------------------------------------------------------------------
  always_comb begin
    gnt         = gnt_q;
    session_cnt = cnt_q;
    bist_reset  = (state_q == ST_GRANT) || (state_q == ST_KILL);
    bist_start  = is_active(state_q);
    done        = (state_q == ST_DONE) ? owner_q : '0;
    pass        = (state_q == ST_DONE) && pass_q;
  end

`ifdef BIST_TIMEOUT_EN
  logic [TO_W-1:0] wd_q, wd_d;
  logic            tout_q, tout_d;

  // Counts START/RUN cycles; wd_q equals the number of active cycles elapsed
  always_comb begin
    wd_d   = is_active(state_q) ? (wd_q + TO_W'(1)) : '0;
    tout_d = (state_q == ST_KILL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q   <= '0;
      tout_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      tout_q <= tout_d;
    end
  end

  assign wd_expire = is_active(state_q) && (wd_q == TO_W'(TIMEOUT_CYC - 1));
  assign timeout   = (state_q == ST_DONE) && tout_q;
`else
  logic [TO_W-1:0] unused_cfg;
  assign unused_cfg = TO_W'(TIMEOUT_CYC);
  assign wd_expire  = 1'b0;
  assign timeout    = 1'b0;
`endif

endmodule
`default_nettype wire
